// File: rtl/nx_frame_packer.sv
// nx_frame_packer: collects WORD_W-bit words from a valid/ready stream into a
// ROWS x COLS frame. It presents the finished frame and per-row parity on a
// second valid/ready handshake. Fill order is row 1 first; within a row the
// order runs from column COLS-1 down to 0.
module nx_frame_packer #(
  parameter int WORD_W = 15,
  parameter int ROWS   = 2,
  parameter int COLS   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:1][0:4]  in_word,
  input  logic             flush,
  output logic             frame_valid,
  input  logic             frame_ready,
  output logic [3:1][0:4]  frame_data [1:ROWS][COLS-1:0],
  output logic [1:ROWS]    row_parity,
  output logic [3:0]       fill_count,
  output logic [7:0]       abort_cnt
);

  localparam logic [0:0] FILL = 1'b0;
  localparam logic [0:0] HOLD = 1'b1;
  localparam int FRAME_WORDS = ROWS * COLS;

  logic [0:0]        state;
  logic [WORD_W-1:0] word_flat;
  logic              word_par;
  logic              accept;
  logic              do_flush;
  logic              last_word;

  assign word_flat   = in_word;
  assign word_par    = ^word_flat;
  assign in_ready    = (state == FILL);
  assign frame_valid = (state == HOLD);
  // flush beats a word presented in the same cycle
  assign accept      = in_ready && in_valid && !flush;
  // only a flush that actually drops words counts as an abort
  assign do_flush    = in_ready && flush && (fill_count != 4'd0);
  assign last_word   = (int'(fill_count) == FRAME_WORDS - 1);

  // fill/hold sequencing, fill position and abort counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= FILL;
      fill_count <= '0;
      abort_cnt  <= '0;
    end else if (state == FILL) begin
      if (do_flush) begin
        fill_count <= '0;
        if (abort_cnt != 8'hFF) abort_cnt <= abort_cnt + 8'd1;
      end else if (accept) begin
        fill_count <= fill_count + 4'd1;
        if (last_word) state <= HOLD;
      end
    end else if (frame_ready) begin
      // handoff cycle: no word is taken until the next cycle
      state      <= FILL;
      fill_count <= '0;
    end
  end

  // write the accepted word into its slot; old contents persist otherwise
  always_ff @(posedge clk) begin
    for (int r = 1; r <= ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        if (rst)
          frame_data[r][c] <= '0;
        else if (accept && int'(fill_count) == (r - 1) * COLS + (COLS - 1 - c))
          frame_data[r][c] <= in_word;
      end
    end
  end

  // running row parity; the first word of a frame restarts every row
  always_ff @(posedge clk) begin
    if (rst || do_flush) begin
      row_parity <= '0;
    end else if (accept) begin
      for (int r = 1; r <= ROWS; r++) begin
        if (fill_count == 4'd0)
          row_parity[r] <= (int'(fill_count) / COLS == r - 1) ? word_par : 1'b0;
        else if (int'(fill_count) / COLS == r - 1)
          row_parity[r] <= row_parity[r] ^ word_par;
      end
    end
  end

endmodule

// File: tb/tb_nx_frame_packer.sv
// Bench for nx_frame_packer: a table of cycle vectors for the first frame and
// hand sequences for hold, flush, saturation and reset. Accepted words go into
// a scoreboard queue. Each completed frame is popped from that queue and
// checked against the DUT frame.
module tb_nx_frame_packer;
  localparam int ROWS = 2, COLS = 4, NW = ROWS * COLS;

  logic clk = 1'b0;
  logic rst, in_valid, in_ready, flush, frame_valid, frame_ready;
  logic [3:1][0:4] in_word;
  logic [3:1][0:4] frame_data [1:ROWS][COLS-1:0];
  logic [1:ROWS]   row_parity;
  logic [3:0]      fill_count;
  logic [7:0]      abort_cnt;

  int n_chk = 0, n_fail = 0;
  logic [14:0] exp_q[$];
  logic [14:0] cur_frame [NW];
  int m_fill = 0, m_abort = 0;
  bit m_hold = 1'b0;

  typedef struct {
    logic [14:0] w;
    logic        f;
    logic [3:0]  efill;
    logic        efv;
  } vec_t;
  vec_t tbl [12];

  always #5 clk = ~clk;

  nx_frame_packer #(.WORD_W(15), .ROWS(ROWS), .COLS(COLS)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_word(in_word), .flush(flush), .frame_valid(frame_valid),
    .frame_ready(frame_ready), .frame_data(frame_data),
    .row_parity(row_parity), .fill_count(fill_count), .abort_cnt(abort_cnt)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // drive one cycle and advance the reference model on the same edge
  task automatic cycle(input logic v, input logic [14:0] w, input logic f, input logic fr);
    in_valid = v; in_word = w; flush = f; frame_ready = fr;
    step();
    if (!m_hold) begin
      if (f && m_fill > 0) begin
        m_fill = 0;
        exp_q.delete();
        if (m_abort < 255) m_abort++;
      end else if (v && !f) begin
        exp_q.push_back(w);
        m_fill++;
        if (m_fill == NW) m_hold = 1'b1;
      end
    end else if (fr) begin
      m_hold = 1'b0;
      m_fill = 0;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b1; in_word = 15'h7fff; flush = 1'b0; frame_ready = 1'b1;
    step();
    rst = 1'b0; in_valid = 1'b0; frame_ready = 1'b0;
    m_fill = 0; m_abort = 0; m_hold = 1'b0;
    exp_q.delete();
  endtask

  task automatic check_state(input string tag);
    chk({tag, " fill_count"}, 32'(fill_count), 32'(m_fill));
    chk({tag, " frame_valid"}, 32'(frame_valid), 32'(m_hold));
    chk({tag, " in_ready"}, 32'(in_ready), 32'(!m_hold));
    chk({tag, " abort_cnt"}, 32'(abort_cnt), 32'(m_abort));
  endtask

  task automatic check_zero(input string tag);
    for (int r = 1; r <= ROWS; r++)
      for (int c = 0; c < COLS; c++)
        chk($sformatf("%s data[%0d][%0d]", tag, r, c), 32'(frame_data[r][c]), 32'd0);
    chk({tag, " row_parity"}, 32'(row_parity), 32'd0);
  endtask

  // compare DUT frame against the last frame popped from the scoreboard
  task automatic compare_frame(input string tag);
    logic [1:ROWS] ep;
    ep = '0;
    for (int k = 0; k < NW; k++) begin
      int r, c;
      r = 1 + k / COLS;
      c = COLS - 1 - (k % COLS);
      chk($sformatf("%s data[%0d][%0d]", tag, r, c), 32'(frame_data[r][c]), 32'(cur_frame[k]));
      ep[r] = ep[r] ^ (^cur_frame[k]);
    end
    chk({tag, " row_parity"}, 32'(row_parity), 32'(ep));
  endtask

  task automatic check_frame(input string tag);
    if (exp_q.size() < NW) begin
      n_chk++; n_fail++;
      $display("FAIL %s scoreboard: got %0d queued words required %0d", tag, exp_q.size(), NW);
    end else begin
      for (int k = 0; k < NW; k++) cur_frame[k] = exp_q.pop_front();
      compare_frame(tag);
    end
  endtask

  initial begin
    for (int k = 0; k < 8; k++)
      tbl[k] = '{w: 15'(k + 1), f: 1'b0, efill: 4'(k + 1), efv: (k == 7)};
    tbl[8]  = '{w: 15'h7abc, f: 1'b0, efill: 4'd8, efv: 1'b1};
    tbl[9]  = '{w: 15'h1234, f: 1'b1, efill: 4'd8, efv: 1'b1};
    tbl[10] = '{w: 15'h5555, f: 1'b0, efill: 4'd8, efv: 1'b1};
    tbl[11] = '{w: 15'h2aaa, f: 1'b1, efill: 4'd8, efv: 1'b1};

    rst = 1'b1; in_valid = 1'b0; in_word = '0; flush = 1'b0; frame_ready = 1'b0;
    step();
    do_reset();
    check_state("reset");
    check_zero("reset");

    // first frame, then hold-time inputs that must be ignored
    for (int i = 0; i < 12; i++) begin
      cycle(1'b1, tbl[i].w, tbl[i].f, 1'b0);
      chk($sformatf("vec%0d fill_count", i), 32'(fill_count), 32'(tbl[i].efill));
      chk($sformatf("vec%0d frame_valid", i), 32'(frame_valid), 32'(tbl[i].efv));
    end
    check_frame("frame1");
    chk("frame1 [1][3]", 32'(frame_data[1][3]), 32'h1);
    chk("frame1 [1][0]", 32'(frame_data[1][0]), 32'h4);
    chk("frame1 [2][3]", 32'(frame_data[2][3]), 32'h5);
    chk("frame1 [2][0]", 32'(frame_data[2][0]), 32'h8);
    chk("frame1 parity", 32'(row_parity), 32'b10);
    check_state("frame1");

    for (int i = 0; i < 10; i++) cycle(1'b1, 15'(16'h3c00 + i * 7), 1'b0, 1'b0);
    compare_frame("stall");
    check_state("stall");
    cycle(1'b1, 15'h0bad, 1'b0, 1'b1);
    check_state("handoff");
    compare_frame("retain");

    // partial frame with odd-parity words, then flush with a word presented
    cycle(1'b1, 15'h0001, 1'b0, 1'b0);
    cycle(1'b1, 15'h0002, 1'b0, 1'b0);
    cycle(1'b1, 15'h0004, 1'b0, 1'b0);
    chk("partial parity", 32'(row_parity), 32'b10);
    cycle(1'b1, 15'h0044, 1'b1, 1'b0);
    check_state("flush");
    chk("flush parity", 32'(row_parity), 32'd0);
    for (int k = 0; k < NW; k++) cycle(1'b1, 15'(16'h0100 + k * 16'h0123), 1'b0, 1'b0);
    check_frame("frame2");
    chk("frame2 first", 32'(frame_data[1][3]), 32'h0100);

    // flush while holding is ignored
    cycle(1'b1, 15'h5555, 1'b1, 1'b0);
    check_state("hold flush");
    compare_frame("hold flush");
    cycle(1'b0, 15'h0, 1'b0, 1'b1);
    // flush with nothing collected is not an abort
    cycle(1'b0, 15'h0, 1'b1, 1'b0);
    check_state("empty flush");

    // abort counter saturation
    for (int i = 0; i < 300; i++) begin
      cycle(1'b1, 15'(i + 1), 1'b0, 1'b0);
      cycle(1'b1, 15'h0, 1'b1, 1'b0);
      if (i == 99) check_state("abort mid");
    end
    check_state("abort sat");

    // reset mid-fill
    for (int k = 0; k < 5; k++) cycle(1'b1, 15'(16'h0700 + k), 1'b0, 1'b0);
    do_reset();
    check_state("rst fill");
    check_zero("rst fill");

    // reset while holding a frame
    for (int k = 0; k < NW; k++) cycle(1'b1, 15'(16'h6000 + k * 16'h0311), 1'b0, 1'b0);
    check_frame("frame3");
    do_reset();
    check_state("rst hold");
    check_zero("rst hold");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
